// File: rtl/genius_pkg.sv
// Shared types and constants for the Genius (Simon) game sequencer.
// Maps remote button codes onto colour/START events.
package genius_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADD,
      ST_SHOW_ON,
      ST_SHOW_OFF,
      ST_WAIT_IN,
      ST_CHECK,
      ST_LOSE,
      ST_WIN
   } state_e;

   localparam logic [2:0] CODE_COL0  = 3'b001;
   localparam logic [2:0] CODE_COL1  = 3'b010;
   localparam logic [2:0] CODE_COL2  = 3'b011;
   localparam logic [2:0] CODE_COL3  = 3'b110;
   localparam logic [2:0] CODE_START = 3'b100;

   // x^8 + x^6 + x^5 + x^4 + 1 -> feedback from bits 7,5,4,3
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   typedef struct packed {
      logic       valid;
      logic       start;
      logic [1:0] colour;
   } btn_evt_t;

   function automatic btn_evt_t decode_code(input logic [2:0] code);
      btn_evt_t e;
      e = '0;
      case (code)
         CODE_COL0:  e = '{valid: 1'b1, start: 1'b0, colour: 2'd0};
         CODE_COL1:  e = '{valid: 1'b1, start: 1'b0, colour: 2'd1};
         CODE_COL2:  e = '{valid: 1'b1, start: 1'b0, colour: 2'd2};
         CODE_COL3:  e = '{valid: 1'b1, start: 1'b0, colour: 2'd3};
         CODE_START: e = '{valid: 1'b1, start: 1'b1, colour: 2'd0};
         default:    e = '0;
      endcase
      return e;
   endfunction

   function automatic logic [3:0] onehot4(input logic [1:0] c);
      return 4'b0001 << c;
   endfunction

endpackage

// File: rtl/genius_lfsr.sv
// Free-running 8-bit Fibonacci LFSR; only the two colour bits leave the block.
module genius_lfsr
   import genius_pkg::*;
#(
   parameter logic [7:0] SEED = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   output logic [1:0] colour_o
);

   logic [7:0] lfsr_q, lfsr_d;

   assign lfsr_d   = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
   assign colour_o = lfsr_q[1:0];

   always_ff @(posedge clk) begin
      if (!rst) lfsr_q <= SEED;
      else      lfsr_q <= lfsr_d;
   end

endmodule

// File: rtl/genius_game_ctrl.sv
// Genius game sequencer: grows a random colour sequence, plays it on the
// LEDs and checks the player's remote presses against it.
module genius_game_ctrl
   import genius_pkg::*;
#(
   parameter int         MAX_LEN     = 16,
   parameter int         SHOW_CYC    = 50,
   parameter int         GAP_CYC     = 20,
   parameter int         TIMEOUT_CYC = 1000,
   parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_rdy,
   input  logic [2:0] btn_code,
   output logic [3:0] led,
   output logic [4:0] level,
   output logic       busy,
   output logic       game_over,
   output logic       win
);

   localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   state_e        state_q, state_d;
   logic [4:0]    level_q, level_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [15:0]   cnt_q, cnt_d;
   logic [15:0]   tmo_q, tmo_d;
   logic [1:0]    col_q, col_d;
   logic          shown_q, shown_d;
   logic          rdy_q;
   logic          seq_we;
   logic [1:0]    seq_q [MAX_LEN];
   logic [1:0]    lfsr_col;
   btn_evt_t      evt;
   logic          evt_fire;
   logic          is_last;

   genius_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
      .clk      (clk),
      .rst      (rst),
      .colour_o (lfsr_col)
   );

   // One event per press: rising edge of rdy with a recognised code.
   assign evt      = decode_code(btn_code);
   assign evt_fire = btn_rdy & ~rdy_q & evt.valid;
   assign is_last  = (5'(idx_q) == level_q - 5'd1);

   always_comb begin
      state_d = state_q;
      level_d = level_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      tmo_d   = tmo_q;
      col_d   = col_q;
      shown_d = shown_q;
      seq_we  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (evt_fire && evt.start) state_d = ST_ADD;
         end
         ST_ADD: begin
            seq_we  = 1'b1;
            level_d = level_q + 5'd1;
            idx_d   = '0;
            cnt_d   = '0;
            state_d = ST_SHOW_ON;
         end
         ST_SHOW_ON: begin
            if (cnt_q == 16'(SHOW_CYC - 1)) begin
               cnt_d   = '0;
               state_d = ST_SHOW_OFF;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         ST_SHOW_OFF: begin
            if (cnt_q == 16'(GAP_CYC - 1)) begin
               cnt_d = '0;
               if (is_last) begin
                  idx_d   = '0;
                  tmo_d   = '0;
                  shown_d = 1'b0;
                  state_d = ST_WAIT_IN;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = ST_SHOW_ON;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         ST_WAIT_IN: begin
            if (evt_fire && !evt.start) begin
               col_d   = evt.colour;
               shown_d = 1'b1;
               state_d = ST_CHECK;
            end else if (tmo_q == 16'(TIMEOUT_CYC - 1)) begin
               state_d = ST_LOSE;
            end else begin
               tmo_d = tmo_q + 16'd1;
            end
         end
         ST_CHECK: begin
            if (col_q != seq_q[idx_q]) begin
               state_d = ST_LOSE;
            end else if (!is_last) begin
               idx_d   = idx_q + 1'b1;
               tmo_d   = '0;
               state_d = ST_WAIT_IN;
            end else if (level_q == 5'(MAX_LEN)) begin
               state_d = ST_WIN;
            end else begin
               state_d = ST_ADD;
            end
         end
         ST_LOSE, ST_WIN: begin
            if (evt_fire && evt.start) begin
               level_d = '0;
               idx_d   = '0;
               state_d = ST_ADD;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         level_q <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         tmo_q   <= '0;
         col_q   <= '0;
         shown_q <= 1'b0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         level_q <= level_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
         col_q   <= col_d;
         shown_q <= shown_d;
         rdy_q   <= btn_rdy;
      end
   end

   // Sequence contents are don't-care after reset, so no reset here.
   always_ff @(posedge clk) begin
      if (seq_we) seq_q[level_q[IW-1:0]] <= lfsr_col;
   end

   always_comb begin
      led = 4'b0000;
      if (state_q == ST_SHOW_ON)                 led = onehot4(seq_q[idx_q]);
      else if (state_q == ST_WAIT_IN && shown_q) led = onehot4(col_q);
   end

   assign level     = level_q;
   assign busy      = (state_q == ST_SHOW_ON) || (state_q == ST_SHOW_OFF);
   assign game_over = (state_q == ST_LOSE);
   assign win       = (state_q == ST_WIN);

endmodule

// File: tb/tb_genius_game_ctrl.sv
// Randomised bench for genius_game_ctrl against a queue-based game model.
module tb_genius_game_ctrl;

   localparam int ML = 3;
   localparam int SC = 50;
   localparam int GC = 20;
   localparam int TO = 1000;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       btn_rdy = 1'b0;
   logic [2:0] btn_code = 3'b000;
   logic [3:0] led;
   logic [4:0] level;
   logic       busy, game_over, win;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   genius_game_ctrl #(
      .MAX_LEN(ML), .SHOW_CYC(SC), .GAP_CYC(GC), .TIMEOUT_CYC(TO), .LFSR_SEED(8'hA5)
   ) dut (
      .clk(clk), .rst(rst), .btn_rdy(btn_rdy), .btn_code(btn_code),
      .led(led), .level(level), .busy(busy), .game_over(game_over), .win(win)
   );

   // Colour source model: polynomial feedback stepped every clock.
   logic [7:0] m_lfsr;
   always @(posedge clk) m_lfsr <= !rst ? 8'hA5 : {m_lfsr[6:0], ^(m_lfsr & 8'b1011_1000)};

   logic [1:0] exp_seq [$];
   logic [7:0] lfsr_at [1:2];

   // Playback recorder: runs of constant LED value while busy.
   typedef struct { logic [3:0] led; int len; } run_t;
   run_t       runs [$];
   logic [3:0] cur_led = 4'h0;
   int         cur_len = 0;

   always @(negedge clk) begin
      if (!rst) cur_len = 0;
      else if (busy === 1'b1) begin
         if (cur_len > 0 && led === cur_led) cur_len++;
         else begin
            if (cur_len > 0) runs.push_back(run_t'{cur_led, cur_len});
            cur_led = led;
            cur_len = 1;
         end
      end else if (cur_len > 0) begin
         runs.push_back(run_t'{cur_led, cur_len});
         cur_len = 0;
      end
   end

   function automatic logic [2:0] code_of(input logic [1:0] c);
      case (c)
         2'd0:    return 3'b001;
         2'd1:    return 3'b010;
         2'd2:    return 3'b011;
         default: return 3'b110;
      endcase
   endfunction

   function automatic bit play_matches();
      logic [3:0] want;
      if (runs.size() != 2 * exp_seq.size()) return 1'b0;
      for (int i = 0; i < exp_seq.size(); i++) begin
         want = 4'b0001 << exp_seq[i];
         if (runs[2*i].led !== want || runs[2*i].len != SC) return 1'b0;
         if (runs[2*i+1].led !== 4'h0 || runs[2*i+1].len != GC) return 1'b0;
      end
      return 1'b1;
   endfunction

   // Hold rdy for 'hold' cycles; remember the model LFSR one and two cycles in.
   task automatic press(input logic [2:0] code, input int hold);
      @(negedge clk);
      btn_rdy  = 1'b1;
      btn_code = code;
      for (int i = 1; i <= hold; i++) begin
         @(negedge clk);
         if (i <= 2) lfsr_at[i] = m_lfsr;
      end
      btn_rdy  = 1'b0;
      btn_code = 3'($urandom);
   endtask

   task automatic wait_play(output bit ok);
      int n;
      ok = 1'b0;
      n  = 0;
      while (busy !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      if (busy !== 1'b1) return;
      n = 0;
      while (busy === 1'b1 && n < ML * (SC + GC) + 10) begin @(negedge clk); n++; end
      if (busy === 1'b0) ok = 1'b1;
      #1;
   endtask

   // Play back the whole expected sequence; the final correct press grows it.
   task automatic replay(output bit led_ok);
      int  n;
      bit  last;
      led_ok = 1'b1;
      n = exp_seq.size();
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, 20)) @(negedge clk);
         last = (i == n - 1);
         if (last) runs.delete();
         press(code_of(exp_seq[i]), 4 + $urandom_range(0, 3));
         if (!last && led !== (4'b0001 << exp_seq[i])) led_ok = 1'b0;
      end
      if (n < ML) exp_seq.push_back(lfsr_at[2][1:0]);
   endtask

   task automatic test_reset;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++; if (led !== 4'h0)      begin bad++; $display("FAIL rst_led: got %0h want 0", led); end
      total++; if (level !== 5'd0)    begin bad++; $display("FAIL rst_level: got %0d want 0", level); end
      total++; if (busy !== 1'b0)     begin bad++; $display("FAIL rst_busy: got %0b want 0", busy); end
      total++; if (game_over !== 1'b0) begin bad++; $display("FAIL rst_game_over: got %0b want 0", game_over); end
      total++; if (win !== 1'b0)      begin bad++; $display("FAIL rst_win: got %0b want 0", win); end
      rst = 1'b1;
   endtask

   task automatic test_idle_ignore;
      press(code_of(2'($urandom)), 4);
      press(3'b111, 4);
      repeat (5) @(negedge clk);
      total++; if (level !== 5'd0) begin bad++; $display("FAIL idle_level: got %0d want 0", level); end
      total++; if (busy !== 1'b0)  begin bad++; $display("FAIL idle_busy: got %0b want 0", busy); end
      total++; if (led !== 4'h0)   begin bad++; $display("FAIL idle_led: got %0h want 0", led); end
   endtask

   task automatic test_start;
      bit ok;
      exp_seq.delete();
      runs.delete();
      press(3'b100, 4 + $urandom_range(0, 3));
      exp_seq.push_back(lfsr_at[1][1:0]);
      wait_play(ok);
      total++; if (!ok)                begin bad++; $display("FAIL start_play_done: got %0b want 1", ok); end
      total++; if (level !== 5'd1)     begin bad++; $display("FAIL start_level: got %0d want 1", level); end
      total++; if (!play_matches())    begin bad++; $display("FAIL start_playback: got %0d runs want %0d", runs.size(), 2 * exp_seq.size()); end
      total++; if (led !== 4'h0)       begin bad++; $display("FAIL start_wait_led: got %0h want 0", led); end
   endtask

   task automatic test_correct_round;
      bit ok, led_ok;
      replay(led_ok);
      wait_play(ok);
      total++; if (!ok)             begin bad++; $display("FAIL round_play_done: got %0b want 1", ok); end
      total++; if (level !== 5'd2)  begin bad++; $display("FAIL round_level: got %0d want 2", level); end
      total++; if (!play_matches()) begin bad++; $display("FAIL round_playback: got %0d runs want %0d", runs.size(), 2 * exp_seq.size()); end
   endtask

   task automatic test_wrong;
      logic [2:0] junk [4];
      logic [1:0] c;
      junk[0] = 3'b111; junk[1] = 3'b000; junk[2] = 3'b101; junk[3] = 3'b100;
      for (int i = 0; i < 4; i++) press(junk[i], 4 + $urandom_range(0, 2));
      total++; if (game_over !== 1'b0) begin bad++; $display("FAIL junk_game_over: got %0b want 0", game_over); end
      total++; if (level !== 5'd2)     begin bad++; $display("FAIL junk_level: got %0d want 2", level); end
      total++; if (busy !== 1'b0)      begin bad++; $display("FAIL junk_busy: got %0b want 0", busy); end
      total++; if (led !== 4'h0)       begin bad++; $display("FAIL junk_led: got %0h want 0", led); end
      c = exp_seq[0] + 2'($urandom_range(1, 3));
      press(code_of(c), 4 + $urandom_range(0, 3));
      total++; if (game_over !== 1'b1) begin bad++; $display("FAIL wrong_game_over: got %0b want 1", game_over); end
      total++; if (led !== 4'h0)       begin bad++; $display("FAIL wrong_led: got %0h want 0", led); end
      total++; if (win !== 1'b0)       begin bad++; $display("FAIL wrong_win: got %0b want 0", win); end
      total++; if (level !== 5'd2)     begin bad++; $display("FAIL wrong_level: got %0d want 2", level); end
   endtask

   task automatic test_restart;
      bit ok;
      exp_seq.delete();
      runs.delete();
      press(3'b100, 4 + $urandom_range(0, 3));
      exp_seq.push_back(lfsr_at[1][1:0]);
      total++; if (game_over !== 1'b0) begin bad++; $display("FAIL restart_game_over: got %0b want 0", game_over); end
      press(code_of(2'($urandom)), 4);
      wait_play(ok);
      total++; if (!ok)             begin bad++; $display("FAIL restart_play_done: got %0b want 1", ok); end
      total++; if (level !== 5'd1)  begin bad++; $display("FAIL restart_level: got %0d want 1", level); end
      total++; if (!play_matches()) begin bad++; $display("FAIL restart_playback: got %0d runs want %0d", runs.size(), 2 * exp_seq.size()); end
   endtask

   task automatic test_timeout;
      bit ok, led_ok;
      replay(led_ok);
      wait_play(ok);
      total++; if (!ok || level !== 5'd2) begin bad++; $display("FAIL tmo_setup: got level %0d want 2", level); end
      repeat (TO - 1) @(negedge clk);
      total++; if (game_over !== 1'b0) begin bad++; $display("FAIL tmo_early: got %0b want 0", game_over); end
      @(negedge clk);
      total++; if (game_over !== 1'b1) begin bad++; $display("FAIL tmo_lose: got %0b want 1", game_over); end
      total++; if (led !== 4'h0)       begin bad++; $display("FAIL tmo_led: got %0h want 0", led); end
   endtask

   task automatic test_win;
      bit ok, led_ok;
      exp_seq.delete();
      runs.delete();
      press(3'b100, 4 + $urandom_range(0, 3));
      exp_seq.push_back(lfsr_at[1][1:0]);
      wait_play(ok);
      total++; if (!ok || level !== 5'd1) begin bad++; $display("FAIL win_start: got level %0d want 1", level); end
      for (int r = 2; r <= ML; r++) begin
         replay(led_ok);
         total++; if (!led_ok) begin bad++; $display("FAIL win_echo_led: got %0b want 1", led_ok); end
         wait_play(ok);
         total++; if (!ok || level !== 5'(r)) begin bad++; $display("FAIL win_level: got %0d want %0d", level, r); end
         total++; if (!play_matches()) begin bad++; $display("FAIL win_playback: got %0d runs want %0d", runs.size(), 2 * exp_seq.size()); end
      end
      replay(led_ok);
      repeat (2) @(negedge clk);
      total++; if (win !== 1'b1)          begin bad++; $display("FAIL win_flag: got %0b want 1", win); end
      total++; if (level !== 5'(ML))      begin bad++; $display("FAIL win_final_level: got %0d want %0d", level, ML); end
      total++; if (led !== 4'h0)          begin bad++; $display("FAIL win_led: got %0h want 0", led); end
      total++; if (game_over !== 1'b0)    begin bad++; $display("FAIL win_game_over: got %0b want 0", game_over); end
   endtask

   task automatic test_reset_mid_show;
      bit ok;
      press(3'b100, 4);
      total++; if (busy !== 1'b1 || level !== 5'd1) begin bad++; $display("FAIL mid_setup: got busy %0b level %0d want 1 1", busy, level); end
      rst = 1'b0;
      @(negedge clk);
      total++; if (led !== 4'h0)       begin bad++; $display("FAIL mid_rst_led: got %0h want 0", led); end
      total++; if (level !== 5'd0)     begin bad++; $display("FAIL mid_rst_level: got %0d want 0", level); end
      total++; if (busy !== 1'b0)      begin bad++; $display("FAIL mid_rst_busy: got %0b want 0", busy); end
      total++; if (win !== 1'b0 || game_over !== 1'b0) begin bad++; $display("FAIL mid_rst_flags: got %0b%0b want 00", win, game_over); end
      rst = 1'b1;
      exp_seq.delete();
      runs.delete();
      press(3'b100, 4 + $urandom_range(0, 3));
      exp_seq.push_back(lfsr_at[1][1:0]);
      wait_play(ok);
      total++; if (!ok || level !== 5'd1) begin bad++; $display("FAIL post_rst_level: got %0d want 1", level); end
      total++; if (!play_matches()) begin bad++; $display("FAIL post_rst_playback: got %0d runs want %0d", runs.size(), 2 * exp_seq.size()); end
   endtask

   initial begin
      test_reset;
      test_idle_ignore;
      test_start;
      test_correct_round;
      test_wrong;
      test_restart;
      test_timeout;
      test_win;
      test_reset_mid_show;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule

// File: doc/genius_game_ctrl.md
Name: genius_game_ctrl

Overview:
Game sequencer for the Genius (Simon) game. It consumes decoded button events from the IR remote decoder (rdy pulse plus 3-bit button code) and grows a random colour sequence. It plays the sequence on four colour LEDs, then checks the player's remote presses against it. It sits between the remote decoder and the LED/display outputs and owns all game state.

Parameters:
MAX_LEN, 16, maximum sequence length; reaching it ends the game in WIN
SHOW_CYC, 50, cycles each colour is lit during playback
GAP_CYC, 20, dark cycles after each lit colour
TIMEOUT_CYC, 1000, maximum cycles allowed between player presses in WAIT_IN
LFSR_SEED, 8'hA5, non-zero reset value of the colour LFSR

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous reset, active-low
btn_rdy  in  1  decoder valid; held high for 4+ consecutive cycles per press
btn_code  in  3  decoder button code, valid while btn_rdy=1
led  out  4  one-hot colour LEDs (bit n = colour n), 0 = dark
level  out  5  current sequence length, 0..MAX_LEN
busy  out  1  high while playing back (SHOW_ON/SHOW_OFF)
game_over  out  1  high in LOSE
win  out  1  high in WIN

Behaviour:
- Reset (rst=0 at a rising edge): state IDLE, led=0, level=0, busy=0, game_over=0, win=0, lfsr=LFSR_SEED, indices and counters 0.
- Press event: btn_rdy=1 with registered btn_rdy_q=0. Exactly one event per press regardless of rdy hold length. btn_code is sampled on the event cycle.
- Code map: 001→colour0, 010→colour1, 011→colour2, 110→colour3, 100→START. All other codes are ignored (no event).
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Shifts every cycle, never reset mid-game. New colour = lfsr[1:0].
- Sequence memory: MAX_LEN x 2-bit register array, written only in ADD.
- States and transitions:
  - IDLE: START → ADD. Colour events are ignored.
  - ADD (1 cycle): seq[level] ← lfsr[1:0]; level ← level+1; idx ← 0 → SHOW_ON.
  - SHOW_ON: led = onehot(seq[idx]) for SHOW_CYC cycles → SHOW_OFF.
  - SHOW_OFF: led=0 for GAP_CYC cycles. Then if idx=level-1: idx←0, tmo←0 → WAIT_IN; else idx←idx+1 → SHOW_ON.
  - WAIT_IN: a colour event → CHECK with the colour latched. START events are ignored. tmo increments each cycle; reaching TIMEOUT_CYC → LOSE. While in this state, led shows onehot(latched colour) for the last accepted press, otherwise 0.
  - CHECK (1 cycle):
    - colour≠seq[idx] → LOSE.
    - Colour matches and idx<level-1 → idx+1, tmo←0 → WAIT_IN.
    - Colour matches and idx=level-1 → WIN if level=MAX_LEN, else ADD.
  - LOSE / WIN: game_over / win held high and led=0. START → clear level to 0 and flags → ADD.
- Events arriving during ADD/SHOW_ON/SHOW_OFF/CHECK are discarded, not queued.
- busy=1 exactly in SHOW_ON and SHOW_OFF.
- Phase counters are 0-based. SHOW_ON lasts exactly SHOW_CYC cycles (count 0..SHOW_CYC-1). Same rule for GAP_CYC.
- Latency: START event cycle → ADD next cycle → first lit LED on the following cycle.
- Reset asserted mid-playback or mid-input: everything returns to reset values on that edge. The sequence contents are don't-care.

Decomposition:
- Shared package genius_pkg: state encoding constants; colour code constants (remote codes 001/010/011/110/100); a code-to-colour decode function; LFSR tap constant.
- One natural sub-module: genius_lfsr (8-bit free-running LFSR, seed parameter, synchronous active-low reset). The sequence array and FSM stay in the top module.

Test Plan:
- Reset then idle: rst=0 for 2 cycles → led=0, level=0, busy=0, game_over=0, win=0. Colour code 001 with rdy → no state change.
- Start and first playback: code 100 with rdy held 4 cycles → level=1. Exactly one LED is lit for 50 cycles, then 20 dark cycles, then busy=0. The press is counted once.
- Correct round: replay the observed colour (e.g. colour2 → code 011) → level=2. Playback shows 2 colours, the first unchanged.
- Wrong input / invalid code: code 111 → ignored. A wrong colour → game_over=1 and led=0. Code 100 → game_over=0, level=1, playback restarts.
- Timeout: no press for 1000 cycles in WAIT_IN → game_over=1.
- Win and reset mid-show: with MAX_LEN=3, three correct rounds → win=1, level=3. A new game followed by rst=0 during SHOW_ON → all outputs return to reset values on the next edge.
